// File: rtl/seq_magnitude_comparator_if.sv
// ---------------------------------------------------------------------------
// seq_magnitude_comparator_if
//   Handshake bundle between operand producer / result consumer and the
//   digit-serial magnitude comparator.
//
//   Request side  : in_valid, in_ready, a, b, signed_mode
//   Response side : out_valid, out_ready, agb, aeb, alb
//
//   master : drives the request and out_ready (producer/consumer side)
//   slave  : the comparator itself
// ---------------------------------------------------------------------------
interface seq_magnitude_comparator_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;

    logic             out_valid;
    logic             out_ready;
    logic             agb;
    logic             aeb;
    logic             alb;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, agb, aeb, alb
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, agb, aeb, alb
    );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// seq_magnitude_comparator
//   Digit-serial magnitude comparator. Two WIDTH-bit operands are compared
//   DIGIT bits per cycle, most significant digit first, and the compare
//   stops on the first digit that differs. Unsigned or two's-complement
//   ordering is chosen per transaction.
//
//   Ports
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset
//     bus    seq_magnitude_comparator_if.slave
//              in_valid/in_ready  operand handshake (ready only in IDLE)
//              a, b, signed_mode  sampled on accept
//              out_valid/out_ready result handshake
//              agb/aeb/alb        one-hot result, zero when out_valid=0
//
//   Parameters
//     WIDTH  operand width, a multiple of DIGIT
//     DIGIT  bits compared per cycle, 1..WIDTH
//
//   Timing
//     The digit compare is registered before it is acted on, so with the
//     accept at edge T the first digit decision is visible at edge T+2.
//     While the registered result of digit k is being examined, digit k+1
//     is already being compared; an early stop simply discards it.
// ---------------------------------------------------------------------------

// Single-digit unsigned compare.
module seq_mag_digit_cmp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] b_dig,
    output logic             gt,
    output logic             lt
);
    assign gt = (a_dig > b_dig);
    assign lt = (a_dig < b_dig);
endmodule

module seq_magnitude_comparator #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    seq_magnitude_comparator_if.slave   bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CNTW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state_q, state_d;

    // Operands are held in shift registers; the digit under compare is
    // always the top DIGIT bits, which avoids a variable part-select mux.
    logic [WIDTH-1:0]  a_sh, b_sh;
    logic [WIDTH-1:0]  sign_mask;
    logic [CNTW-1:0]   idx_q;

    // vld_pipe[0]: a digit is being issued this cycle
    // vld_pipe[1]: the registered digit result below is valid
    logic [1:0]        vld_pipe;
    logic              d_gt, d_lt, d_last;

    logic              agb_q, aeb_q, alb_q;

    logic              dig_gt, dig_lt;
    logic              accept, issue, last_issue;
    logic              resolve, resolve_diff, resolve_eq;
    logic              out_take;

    seq_mag_digit_cmp #(.DIGIT(DIGIT)) u_dcmp (
        .a_dig (a_sh[WIDTH-1 -: DIGIT]),
        .b_dig (b_sh[WIDTH-1 -: DIGIT]),
        .gt    (dig_gt),
        .lt    (dig_lt)
    );

    // Flipping the sign bit of both operands maps two's-complement order
    // onto unsigned order, so the digit logic never needs to know the mode.
    always_comb begin
        sign_mask            = '0;
        sign_mask[WIDTH-1]   = bus.signed_mode;
    end

    // ---------------------------------------------------------------
    // Next-state and control strobes
    // ---------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        issue        = 1'b0;
        last_issue   = 1'b0;
        resolve_diff = 1'b0;
        resolve_eq   = 1'b0;
        out_take     = 1'b0;

        case (state_q)
            IDLE: begin
                accept = bus.in_valid;
                if (accept) state_d = COMPARE;
            end
            COMPARE: begin
                issue        = vld_pipe[0];
                last_issue   = vld_pipe[0] && (idx_q == CNTW'(NDIG - 1));
                resolve_diff = vld_pipe[1] && (d_gt || d_lt);
                resolve_eq   = vld_pipe[1] && !(d_gt || d_lt) && d_last;
                if (resolve_diff || resolve_eq) state_d = DONE;
            end
            DONE: begin
                out_take = bus.out_ready;
                if (out_take) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resolve = resolve_diff || resolve_eq;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            idx_q    <= '0;
            vld_pipe <= '0;
            d_gt     <= 1'b0;
            d_lt     <= 1'b0;
            d_last   <= 1'b0;
            agb_q    <= 1'b0;
            aeb_q    <= 1'b0;
            alb_q    <= 1'b0;
        end else begin
            if (accept) begin
                a_sh     <= bus.a ^ sign_mask;
                b_sh     <= bus.b ^ sign_mask;
                idx_q    <= '0;
                vld_pipe <= 2'b01;
            end else if (state_q == COMPARE) begin
                if (issue) begin
                    a_sh   <= a_sh << DIGIT;
                    b_sh   <= b_sh << DIGIT;
                    d_gt   <= dig_gt;
                    d_lt   <= dig_lt;
                    d_last <= last_issue;
                    if (!last_issue) idx_q <= idx_q + CNTW'(1);
                end
                // Issue bit stops after the last digit; result bit trails it.
                if (resolve) vld_pipe <= '0;
                else         vld_pipe <= {vld_pipe[0], vld_pipe[0] & ~last_issue};
                if (resolve) begin
                    agb_q <= d_gt;
                    alb_q <= d_lt;
                    aeb_q <= resolve_eq;
                end
            end

            if (out_take) begin
                agb_q <= 1'b0;
                aeb_q <= 1'b0;
                alb_q <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    // in_ready is qualified by rst_n so it drops immediately on reset.
    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = (state_q == DONE);
    assign bus.agb       = agb_q;
    assign bus.aeb       = aeb_q;
    assign bus.alb       = alb_q;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
module tb_seq_magnitude_comparator;
    localparam int NU = 4;

    // Unit configurations: 0: W8/D4, 1: W32/D4, 2: W32/D1, 3: W32/D32
    function automatic int cfg_w(int u);
        return (u == 0) ? 8 : 32;
    endfunction
    function automatic int cfg_d(int u);
        case (u)
            0, 1:    return 4;
            2:       return 1;
            default: return 32;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NU-1:0]        rst_n_v, in_valid_v, sm_v, out_ready_v;
    logic [NU-1:0][31:0]  a_v, b_v;
    logic [NU-1:0]        in_ready_v, out_valid_v, agb_v, aeb_v, alb_v;

    int n_chk  = 0;
    int n_pass = 0;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        localparam int W = cfg_w(g);
        seq_magnitude_comparator_if #(.WIDTH(W)) ifc ();
        assign ifc.in_valid    = in_valid_v[g];
        assign ifc.a           = a_v[g][W-1:0];
        assign ifc.b           = b_v[g][W-1:0];
        assign ifc.signed_mode = sm_v[g];
        assign ifc.out_ready   = out_ready_v[g];
        assign in_ready_v[g]   = ifc.in_ready;
        assign out_valid_v[g]  = ifc.out_valid;
        assign agb_v[g]        = ifc.agb;
        assign aeb_v[g]        = ifc.aeb;
        assign alb_v[g]        = ifc.alb;
        seq_magnitude_comparator #(.WIDTH(W), .DIGIT(cfg_d(g))) dut (
            .clk   (clk),
            .rst_n (rst_n_v[g]),
            .bus   (ifc.slave)
        );
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [2:0] flags(int u);
        return {agb_v[u], aeb_v[u], alb_v[u]};
    endfunction

    // {out_valid, agb, aeb, alb, in_ready}
    function automatic logic [4:0] snap(int u);
        return {out_valid_v[u], agb_v[u], aeb_v[u], alb_v[u], in_ready_v[u]};
    endfunction

    // Reference: flags from the language's own compare operators.
    function automatic logic [2:0] ref_flags(logic [31:0] a, logic [31:0] b, logic sm);
        logic gt, lt;
        gt = sm ? ($signed(a) > $signed(b)) : (a > b);
        lt = sm ? ($signed(a) < $signed(b)) : (a < b);
        return {gt, !(gt || lt), lt};
    endfunction

    // Reference: latency = 2 + first differing digit, else 1 + NDIG.
    function automatic int ref_lat(int w, int d, logic [31:0] a, logic [31:0] b, logic sm);
        logic [63:0] x, y, m;
        x = {32'd0, a};
        y = {32'd0, b};
        if (sm) begin
            x[w-1] = ~x[w-1];
            y[w-1] = ~y[w-1];
        end
        m = (64'd1 << d) - 64'd1;
        for (int k = 0; k < w / d; k++) begin
            if (((x >> (w - d * (k + 1))) & m) != ((y >> (w - d * (k + 1))) & m))
                return 2 + k;
        end
        return 1 + w / d;
    endfunction

    // One full transaction: accept, scramble inputs, measure latency, release.
    task automatic run_op(int u, logic [31:0] a, logic [31:0] b, logic sm,
                          logic [2:0] ef, int el, string name);
        int lat;
        lat = -1;
        for (int i = 0; i < 50 && !in_ready_v[u]; i++) @(negedge clk);
        check({name, " in_ready idle"}, in_ready_v[u], 1);
        a_v[u] = a; b_v[u] = b; sm_v[u] = sm;
        in_valid_v[u] = 1'b1; out_ready_v[u] = 1'b0;
        @(posedge clk); #1;
        in_valid_v[u] = 1'b0;
        a_v[u] = ~a; b_v[u] = a ^ 32'h5a5a_a5a5; sm_v[u] = ~sm;
        check({name, " in_ready busy"}, in_ready_v[u], 0);
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (out_valid_v[u]) begin
                lat = c;
                break;
            end
        end
        check({name, " latency"}, lat, el);
        check({name, " flags"}, flags(u), ef);
        out_ready_v[u] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[u] = 1'b0;
        check({name, " after take"}, snap(u), 5'b0_000_1);
    endtask

    typedef struct {
        int          u;
        logic [31:0] a;
        logic [31:0] b;
        logic        sm;
        logic [2:0]  ef;   // {agb, aeb, alb}
        int          lat;
        string       name;
    } vec_t;

    vec_t vt[$];

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hffff_ffff;
            2:       return 32'h8000_0000;
            3:       return 32'h7fff_ffff;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt.push_back('{0, 32'h5a, 32'h3f, 1'b0, 3'b100, 2, "w8 5A>3F"});
        vt.push_back('{0, 32'h5a, 32'h5b, 1'b0, 3'b001, 3, "w8 5A<5B"});
        vt.push_back('{0, 32'ha5, 32'ha5, 1'b0, 3'b010, 3, "w8 A5==A5"});
        vt.push_back('{0, 32'h80, 32'h7f, 1'b1, 3'b001, 2, "w8 s 80<7F"});
        vt.push_back('{0, 32'h80, 32'h7f, 1'b0, 3'b100, 2, "w8 u 80>7F"});
        vt.push_back('{0, 32'hff, 32'h01, 1'b1, 3'b001, 2, "w8 s -1<1"});
        vt.push_back('{0, 32'hfe, 32'hff, 1'b1, 3'b001, 3, "w8 s -2<-1"});
        vt.push_back('{0, 32'h00, 32'h00, 1'b1, 3'b010, 3, "w8 s 0==0"});
        vt.push_back('{1, 32'h1, 32'h2, 1'b0, 3'b001, 9, "w32d4 1<2"});
        vt.push_back('{1, 32'h0, 32'h0, 1'b0, 3'b010, 9, "w32d4 0==0"});
        vt.push_back('{1, 32'hffffffff, 32'h0, 1'b0, 3'b100, 2, "w32d4 u max>0"});
        vt.push_back('{1, 32'hffffffff, 32'h0, 1'b1, 3'b001, 2, "w32d4 s -1<0"});
        vt.push_back('{1, 32'h12345678, 32'h12345679, 1'b0, 3'b001, 9, "w32d4 last digit"});
        vt.push_back('{1, 32'h12345678, 32'h12340678, 1'b0, 3'b100, 6, "w32d4 digit4"});
        vt.push_back('{2, 32'h1, 32'h0, 1'b0, 3'b100, 33, "w32d1 lsb"});
        vt.push_back('{2, 32'h80000000, 32'h0, 1'b1, 3'b001, 2, "w32d1 s min<0"});
        vt.push_back('{2, 32'h7fffffff, 32'h7fffffff, 1'b1, 3'b010, 33, "w32d1 s max==max"});
        vt.push_back('{3, 32'h80000000, 32'h7fffffff, 1'b1, 3'b001, 2, "w32d32 s min<max"});
        vt.push_back('{3, 32'h5, 32'h5, 1'b0, 3'b010, 2, "w32d32 5==5"});
        vt.push_back('{3, 32'h0, 32'hffffffff, 1'b0, 3'b001, 2, "w32d32 u 0<max"});

        rst_n_v = '0; in_valid_v = '0; sm_v = '0; out_ready_v = '0;
        a_v = '0; b_v = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < NU; u++) check($sformatf("reset u%0d", u), snap(u), 5'b0_000_0);
        rst_n_v = '1;
        @(posedge clk); #1;

        // Directed table
        foreach (vt[i]) run_op(vt[i].u, vt[i].a, vt[i].b, vt[i].sm, vt[i].ef, vt[i].lat, vt[i].name);

        // Back-pressure: hold out_ready low with noise on the request side.
        a_v[0] = 32'h5a; b_v[0] = 32'h3f; sm_v[0] = 1'b0; in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        for (int c = 0; c < 10 && !out_valid_v[0]; c++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid_v[0] = ~in_valid_v[0];
            a_v[0] = $urandom(); b_v[0] = $urandom(); sm_v[0] = ~sm_v[0];
            @(posedge clk); #1;
            check($sformatf("hold cycle %0d", i), snap(0), 5'b1_100_0);
        end
        in_valid_v[0] = 1'b0; out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        check("hold take", snap(0), 5'b0_000_1);
        // out_ready while idle must not disturb anything.
        @(posedge clk); #1;
        out_ready_v[0] = 1'b0;
        check("idle out_ready", snap(0), 5'b0_000_1);

        // Reset mid-compare on the W32/D4 unit.
        a_v[1] = 32'h1; b_v[1] = 32'h2; sm_v[1] = 1'b0; in_valid_v[1] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[1] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n_v[1] = 1'b0;
        #1;
        check("mid reset immediate", snap(1), 5'b0_000_0);
        @(posedge clk); #1;
        check("mid reset held", snap(1), 5'b0_000_0);
        rst_n_v[1] = 1'b1;
        run_op(1, 32'h1, 32'h2, 1'b0, 3'b001, 9, "post reset 1<2");

        // Randomized + edge values against the reference model.
        for (int u = 2; u < NU; u++) begin
            for (int n = 0; n < 300; n++) begin
                logic [31:0] ra, rb;
                logic        rs;
                ra = pick();
                case ($urandom_range(0, 3))
                    0:       rb = ra;
                    1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
                    default: rb = pick();
                endcase
                rs = 1'($urandom_range(0, 1));
                run_op(u, ra, rb, rs, ref_flags(ra, rb, rs),
                       ref_lat(cfg_w(u), cfg_d(u), ra, rb, rs),
                       $sformatf("rnd u%0d #%0d", u, n));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
